// File: rtl/dff_bank_pipe.sv
// dff_bank_pipe: WIDTH-bit, DEPTH-stage enabled register pipeline with valid tag,
// selectable output polarity, async active-low reset and a saturating toggle
// counter on the last stage for switching-activity estimation.
module dff_bank_pipe #(
  parameter int unsigned      WIDTH   = 8,
  parameter int unsigned      DEPTH   = 2,
  parameter bit               INV_OUT = 1'b1,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int unsigned      CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             EN,
  input  logic [WIDTH-1:0] D,
  input  logic             IN_VALID,
  output logic [WIDTH-1:0] Q,
  output logic             OUT_VALID,
  input  logic             TGL_CLR,
  output logic [CNT_W-1:0] TGL_CNT,
  output logic             TGL_SAT
);

  localparam int unsigned INC_W = $clog2(WIDTH + 1);
  localparam int unsigned SUM_W = (CNT_W + 1 > INC_W) ? CNT_W + 1 : INC_W;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] last_next;
  logic [WIDTH-1:0] diff;
  logic [INC_W-1:0] inc;
  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] tgl_cnt_q;
  logic             tgl_sat_q;

  // Value the last stage would take on an enabled edge.
  generate
    if (DEPTH == 1) begin : g_last_d
      always_comb last_next = D;
    end else begin : g_last_prev
      always_comb last_next = stage_q[DEPTH-2];
    end
  endgenerate

  // Plain shift register: everything advances together on EN, otherwise holds.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RST_VAL;
      end
      valid_q <= '0;
    end else if (EN) begin
      stage_q[0] <= D;
      valid_q[0] <= IN_VALID;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  // Popcount of last-stage bits about to flip, and the widened running sum.
  always_comb begin
    diff = EN ? (last_next ^ stage_q[DEPTH-1]) : '0;
    inc  = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      inc = inc + INC_W'(diff[i]);
    end
    sum = SUM_W'(tgl_cnt_q) + SUM_W'(inc);
  end

  // Saturating toggle counter; clear has priority over any increment.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      tgl_cnt_q <= '0;
      tgl_sat_q <= 1'b0;
    end else if (TGL_CLR) begin
      tgl_cnt_q <= '0;
      tgl_sat_q <= 1'b0;
    end else if (sum > CNT_MAX) begin
      tgl_cnt_q <= '1;
      tgl_sat_q <= 1'b1;
    end else begin
      tgl_cnt_q <= sum[CNT_W-1:0];
    end
  end

  // Counting uses stored polarity; the inversion only applies at the pin.
  assign Q         = INV_OUT ? ~stage_q[DEPTH-1] : stage_q[DEPTH-1];
  assign OUT_VALID = valid_q[DEPTH-1];
  assign TGL_CNT   = tgl_cnt_q;
  assign TGL_SAT   = tgl_sat_q;

endmodule

// File: tb/tb_dff_bank_pipe.sv
// tb_dff_bank_pipe: directed checks of dff_bank_pipe in three configurations
// (default, narrow saturating counter, 3-deep non-inverting with nonzero reset value).
module tb_dff_bank_pipe;

  logic CLK;
  int unsigned n_cmp;
  int unsigned n_err;

  // Config A: defaults (WIDTH 8, DEPTH 2, INV_OUT 1, RST_VAL 0, CNT_W 16)
  logic        rst_a, en_a, iv_a, clr_a;
  logic [7:0]  d_a, q_a;
  logic        ov_a, sat_a;
  logic [15:0] cnt_a;

  // Config B: CNT_W 4
  logic        rst_b, en_b, iv_b, clr_b;
  logic [7:0]  d_b, q_b;
  logic        ov_b, sat_b;
  logic [3:0]  cnt_b;

  // Config C: DEPTH 3, INV_OUT 0, RST_VAL 8'h3C
  logic        rst_c, en_c, iv_c, clr_c;
  logic [7:0]  d_c, q_c;
  logic        ov_c, sat_c;
  logic [15:0] cnt_c;

  dff_bank_pipe u_dut_a (
    .CLK(CLK), .RESETN(rst_a), .EN(en_a), .D(d_a), .IN_VALID(iv_a),
    .Q(q_a), .OUT_VALID(ov_a), .TGL_CLR(clr_a), .TGL_CNT(cnt_a), .TGL_SAT(sat_a)
  );

  dff_bank_pipe #(.CNT_W(4)) u_dut_b (
    .CLK(CLK), .RESETN(rst_b), .EN(en_b), .D(d_b), .IN_VALID(iv_b),
    .Q(q_b), .OUT_VALID(ov_b), .TGL_CLR(clr_b), .TGL_CNT(cnt_b), .TGL_SAT(sat_b)
  );

  dff_bank_pipe #(.DEPTH(3), .INV_OUT(1'b0), .RST_VAL(8'h3C)) u_dut_c (
    .CLK(CLK), .RESETN(rst_c), .EN(en_c), .D(d_c), .IN_VALID(iv_c),
    .Q(q_c), .OUT_VALID(ov_c), .TGL_CLR(clr_c), .TGL_CNT(cnt_c), .TGL_SAT(sat_c)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one posedge, then step off the edge for sampling/driving.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_a = 1'b1; en_a = 1'b0; iv_a = 1'b0; clr_a = 1'b0; d_a = '0;
    rst_b = 1'b1; en_b = 1'b0; iv_b = 1'b0; clr_b = 1'b0; d_b = '0;
    rst_c = 1'b1; en_c = 1'b0; iv_c = 1'b0; clr_c = 1'b0; d_c = '0;

    // T1: async reset with no clock edge yet (first posedge at t=5)
    #1;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    #1;
    check_val("t1_q_a",    32'(q_a),   32'hFF);
    check_val("t1_ov_a",   32'(ov_a),  32'h0);
    check_val("t1_cnt_a",  32'(cnt_a), 32'h0);
    check_val("t1_sat_a",  32'(sat_a), 32'h0);
    check_val("t1_q_c",    32'(q_c),   32'h3C);
    check_val("t1_ov_c",   32'(ov_c),  32'h0);
    #1;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;

    // T2: latency 2 on config A, inverted output
    en_a = 1'b1; d_a = 8'hA5; iv_a = 1'b1;
    tick();
    check_val("t2_e0_q",   32'(q_a),   32'hFF);
    check_val("t2_e0_ov",  32'(ov_a),  32'h0);
    d_a = 8'h00; iv_a = 1'b0;
    tick();
    check_val("t2_e1_q",   32'(q_a),   32'h5A);
    check_val("t2_e1_ov",  32'(ov_a),  32'h1);
    check_val("t2_e1_cnt", 32'(cnt_a), 32'd4);

    // T3: hold for 5 cycles while D and IN_VALID wiggle
    en_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d_a  = 8'(i * 37 + 3);
      iv_a = i[0];
      tick();
    end
    check_val("t3_q",   32'(q_a),   32'h5A);
    check_val("t3_ov",  32'(ov_a),  32'h1);
    check_val("t3_cnt", 32'(cnt_a), 32'd4);

    // T4: clear on the edge that loads 00 into the last stage, then 00->FF->0F
    en_a = 1'b1; iv_a = 1'b0; clr_a = 1'b1; d_a = 8'hFF;
    tick();
    check_val("t4_clr_cnt", 32'(cnt_a), 32'd0);
    check_val("t4_clr_q",   32'(q_a),   32'hFF);
    clr_a = 1'b0; d_a = 8'h0F;
    tick();
    check_val("t4_cnt8",  32'(cnt_a), 32'd8);
    check_val("t4_q00",   32'(q_a),   32'h00);
    d_a = 8'h00;
    tick();
    check_val("t4_cnt12", 32'(cnt_a), 32'd12);
    check_val("t4_qF0",   32'(q_a),   32'hF0);
    check_val("t4_ov",    32'(ov_a),  32'h0);
    en_a = 1'b0;

    // T5: saturation and clear on 4-bit counter
    en_b = 1'b1; d_b = 8'hFF;
    tick();
    check_val("t5_cnt0", 32'(cnt_b), 32'd0);
    d_b = 8'h00;
    tick();
    check_val("t5_cnt8", 32'(cnt_b), 32'd8);
    check_val("t5_sat0", 32'(sat_b), 32'h0);
    tick();
    check_val("t5_cnt15", 32'(cnt_b), 32'd15);
    check_val("t5_sat1",  32'(sat_b), 32'h1);
    d_b = 8'hFF;
    tick();
    check_val("t5_hold15", 32'(cnt_b), 32'd15);
    check_val("t5_sticky", 32'(sat_b), 32'h1);
    clr_b = 1'b1; d_b = 8'h00;
    tick();
    check_val("t5_clr_cnt", 32'(cnt_b), 32'd0);
    check_val("t5_clr_sat", 32'(sat_b), 32'h0);
    clr_b = 1'b0;
    tick();
    check_val("t5_after_clr", 32'(cnt_b), 32'd8);
    check_val("t5_after_sat", 32'(sat_b), 32'h0);
    en_b = 1'b0;

    // T6: 3-deep, non-inverting, reset mid-flight
    en_c = 1'b1; iv_c = 1'b1; d_c = 8'h11;
    tick();
    d_c = 8'h22;
    tick();
    check_val("t6_e1_q", 32'(q_c), 32'h3C);
    d_c = 8'h33;
    tick();
    check_val("t6_lat_q",   32'(q_c),   32'h11);
    check_val("t6_lat_ov",  32'(ov_c),  32'h1);
    check_val("t6_lat_cnt", 32'(cnt_c), 32'd4);
    d_c = 8'h44;
    tick();
    check_val("t6_pre_cnt", 32'(cnt_c), 32'd8);
    rst_c = 1'b0;
    #1;
    check_val("t6_rst_q",   32'(q_c),   32'h3C);
    check_val("t6_rst_ov",  32'(ov_c),  32'h0);
    check_val("t6_rst_cnt", 32'(cnt_c), 32'd0);
    rst_c = 1'b1;
    d_c = 8'h55; iv_c = 1'b1;
    tick();
    d_c = 8'h66; iv_c = 1'b0;
    tick();
    check_val("t6_e2_q",  32'(q_c),  32'h3C);
    check_val("t6_e2_ov", 32'(ov_c), 32'h0);
    d_c = 8'h77;
    tick();
    check_val("t6_e3_q",   32'(q_c),   32'h55);
    check_val("t6_e3_ov",  32'(ov_c),  32'h1);
    check_val("t6_e3_cnt", 32'(cnt_c), 32'd4);
    en_c = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
